// File: rtl/subta_log.sv
// Encoder difference signal: D = SL - SE, sign/log2 of |D|, then log normalised by the scale factor Y.
// Latency: out_valid rises 15-EXP edges after the accept edge (1..15); one leading-one shift per clock.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so a new operand waits for the drain.
module subta_log (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] SL,
  input  logic [14:0] SE,
  input  logic [12:0] Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] D,
  output logic        DS,
  output logic [11:0] DLN
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] tmp_q, tmp_d;    // magnitude being shifted toward bit 14
  logic [3:0]  exp_q, exp_d;    // exponent, counts down from 14
  logic [12:0] y_q, y_d;        // scale factor captured at accept
  logic [15:0] d_q, d_d;
  logic        ds_q, ds_d;
  logic [11:0] dln_q, dln_d;

  // Accept-edge datapath: sign-extend both operands, subtract modulo 2^16,
  // and take the 15-bit magnitude. (-D) mod 2^15 is ~D[14:0] + 1.
  logic [15:0] sli, sei, diff;
  logic [14:0] dqm;
  assign sli  = {{2{SL[13]}}, SL};
  assign sei  = {SE[14], SE};
  assign diff = sli - sei;
  assign dqm  = diff[15] ? (~diff[14:0] + 15'd1) : diff[14:0];

  // Log word and normalisation; 12-bit arithmetic gives the modulo-4096 wrap.
  logic [10:0] dl;
  logic [11:0] dln_calc;
  assign dl       = {exp_q, tmp_q[13:7]};
  assign dln_calc = {1'b0, dl} - 12'(y_q >> 2);

  // Handshakes are decoded from state alone.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign DS        = ds_q;
  assign DLN       = dln_q;

  // Next-state and datapath update: capture on accept, shift in NORM, hold in DONE.
  always_comb begin
    state_d = state_q;
    tmp_d   = tmp_q;
    exp_d   = exp_q;
    y_d     = y_q;
    d_d     = d_q;
    ds_d    = ds_q;
    dln_d   = dln_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d     = diff;
          ds_d    = diff[15];
          tmp_d   = dqm;
          exp_d   = 4'd14;
          y_d     = Y;
          state_d = NORM;
        end
      end
      NORM: begin
        // Stop once the leading one reaches bit 14, or the exponent bottoms
        // out (covers magnitudes 0 and 1).
        if (tmp_q[14] || (exp_q == 4'd0)) begin
          dln_d   = dln_calc;
          state_d = DONE;
        end else begin
          tmp_d = {tmp_q[13:0], 1'b0};
          exp_d = exp_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmp_q   <= '0;
      exp_q   <= '0;
      y_q     <= '0;
      d_q     <= '0;
      ds_q    <= 1'b0;
      dln_q   <= '0;
    end else begin
      state_q <= state_d;
      tmp_q   <= tmp_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
      d_q     <= d_d;
      ds_q    <= ds_d;
      dln_q   <= dln_d;
    end
  end

endmodule

// File: tb/tb_subta_log.sv
// Bench for subta_log: scoreboard of expected D/DS/DLN/latency from a closed-form model,
// monitor compares on every out_valid cycle; directed, random, backpressure and reset cases.
module tb_subta_log;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] SL;
  logic [14:0] SE;
  logic [12:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        DS;
  logic [11:0] DLN;

  subta_log dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SL        (SL),
    .SE        (SE),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .DS        (DS),
    .DLN       (DLN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int ds;
    int dln;
    int n;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int expv);
    vectors = vectors + 1;
    if (act != expv) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(input logic [13:0] sl, input logic [14:0] se, input logic [12:0] y);
    exp_t r;
    int sli, sei, dd, dqm, e, mant, dl;
    sli = $signed(sl);
    sei = $signed(se);
    dd  = (sli - sei) & 65535;
    r.d  = dd;
    r.ds = (dd >> 15) & 1;
    dqm = r.ds ? ((65536 - dd) & 32767) : (dd & 32767);
    e = 0;
    for (int b = 0; b < 15; b++) begin
      if (((dqm >> b) & 1) == 1) e = b;
    end
    mant  = ((dqm << 7) >> e) & 127;
    dl    = e * 128 + mant;
    r.dln = (dl + 4096 - (int'(y) >> 2)) % 4096;
    r.n   = 15 - e;
    r.acc = 0;
    return r;
  endfunction

  // Monitor: pop on each out_valid rise, then hold the popped result for the
  // whole DONE window so stability under backpressure is checked too.
  initial begin
    exp_t cur;
    bit   have_cur;
    bit   prev_ov;
    have_cur = 0;
    prev_ov  = 0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!prev_ov) begin
          chk("result_expected", int'(sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            cur = sbq.pop_front();
            have_cur = 1;
            chk("latency", cyc - cur.acc, cur.n);
          end
        end
        if (have_cur) begin
          chk("D", int'(D), cur.d);
          chk("DS", int'(DS), cur.ds);
          chk("DLN", int'(DLN), cur.dln);
          chk("in_ready_in_done", int'(in_ready), 0);
        end
      end else begin
        have_cur = 0;
        if (sbq.size() != 0) chk("in_ready_busy", int'(in_ready), 0);
      end
      prev_ov = (out_valid === 1'b1);
    end
  end

  // Wait (bounded) for IDLE, present one operand set for one accept edge.
  task automatic accept(input logic [13:0] sl, input logic [14:0] se, input logic [12:0] y);
    exp_t e;
    int   k;
    @(negedge clk);
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", int'(in_ready === 1'b1), 1);
    SL = sl;
    SE = se;
    Y  = y;
    in_valid = 1'b1;
    e = model(sl, se, y);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
    // Scramble inputs while busy; they must be ignored.
    SL = 14'($urandom);
    SE = 15'($urandom);
    Y  = 13'($urandom);
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_wait", int'(out_valid === 1'b1), 1);
  endtask

  task automatic send(input logic [13:0] sl, input logic [14:0] se, input logic [12:0] y, input int hold);
    accept(sl, se, y);
    wait_out();
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drained_out_valid", int'(out_valid), 0);
    chk("drained_in_ready", int'(in_ready), 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_D"}, int'(D), 0);
    chk({tag, "_DS"}, int'(DS), 0);
    chk({tag, "_DLN"}, int'(DLN), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    SL = '0;
    SE = '0;
    Y  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // Directed vectors
    send(14'h0000, 15'h0000, 13'd0,    0);   // DQM=0, N=15
    send(14'd4096, 15'h0000, 13'd544,  0);   // DLN=1400, N=3
    send(14'h0000, 15'd100,  13'd544,  1);   // D=FF9C, DLN=704, N=9
    send(14'h2000, 15'h3FFF, 13'd0,    0);   // D=A001, DLN=1855, N=1
    send(14'h1FFF, 15'h4000, 13'd0,    0);   // D=5FFF, DLN=1855
    send(14'h0000, 15'h0000, 13'd8191, 0);   // DLN wraps to 2049
    send(14'h0001, 15'h0000, 13'd4,    2);   // DQM=1
    send(14'h0000, 15'h0001, 13'd100,  0);   // D=-1
    send(14'h1FFF, 15'h3FFF, 13'd7,    10);  // backpressure 10 cycles

    // Reset during NORM: no output, IDLE next cycle.
    accept(14'h0000, 15'h0000, 13'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    reset = 1'b0;
    check_reset_state("abort_norm");
    repeat (20) @(negedge clk);
    chk("abort_norm_quiet", int'(out_valid), 0);

    // Reset during DONE while held by backpressure.
    accept(14'h2000, 15'h3FFF, 13'd0);
    wait_out();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    reset = 1'b0;
    check_reset_state("abort_done");

    // Reset together with in_valid: nothing accepted.
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    SL = 14'd4096;
    SE = 15'd0;
    Y  = 13'd544;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check_reset_state("rst_vs_valid");
    repeat (20) @(negedge clk);
    chk("rst_vs_valid_quiet", int'(out_valid), 0);

    // Random operands and backpressure.
    for (int i = 0; i < 150; i++) begin
      send(14'($urandom), 15'($urandom), 13'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/subta_log.md
Name: subta_log

Overview:
- Encoder-side counterpart of the decoder reconstruction adder (SR = DQ + SE) in the G.726 ADPCM path.
- Forms the difference signal D = SL - SE (SUBTA), converts D to sign plus base-2 log (LOG), and normalises by the scale factor (SUBTB), producing DLN and DS for the quantizer.
- The log conversion is a sequential leading-one search: one shift per clock.
- Operands are loaded through a valid/ready input; the result is held under a valid/ready output.

Parameters:
none

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous reset, active-high
in_valid  input  1  SL/SE/Y valid
in_ready  output  1  block can accept a new operand set
SL  input  14  input linear PCM sample, two's complement
SE  input  15  signal estimate, two's complement
Y  input  13  quantizer scale factor, unsigned
out_valid  output  1  D/DS/DLN valid
out_ready  input  1  consumer accepts the result
D  output  16  difference signal, two's complement
DS  output  1  sign of D
DLN  output  12  log of |D| normalised by Y, unsigned modulo 4096

Behaviour:
- Reset: state goes to IDLE. in_ready=1 the cycle after reset. out_valid=0, D=0, DS=0, DLN=0. Internal shift register, EXP counter and the captured Y are cleared.
- States:
  - IDLE: in_ready=1. On in_valid, the accept edge goes to NORM.
  - NORM: in_ready=0, out_valid=0.
  - DONE: out_valid=1. Stays in DONE while out_ready=0. On out_ready, goes to IDLE.
- in_ready is decoded from state only. No accept happens in the cycle DONE drains; the minimum initiation interval is N+2 cycles.
- Accept edge (combinational from inputs, then registered):
  - SLI = SL sign-extended to 16 bits; SEI = SE sign-extended to 16 bits.
  - D = (SLI - SEI) mod 65536. DS = D[15].
  - DQM = DS ? (65536 - D) & 32767 : D & 32767 (15 bits).
  - tmp = DQM, EXP = 14, Y captured.
- NORM, each cycle:
  - If tmp[14]=1 or EXP=0, then register:
    - MANT = tmp[13:7]
    - DL = {EXP[3:0], MANT} (11 bits)
    - DLN = (DL + 4096 - (Y>>2)) & 4095
    - then go to DONE.
  - Otherwise tmp <<= 1 and EXP -= 1.
- Equivalent closed form: EXP = floor(log2 DQM) for DQM>=1 (EXP=0 for DQM in {0,1}); MANT = ((DQM<<7)>>EXP) & 127.
- Latency: out_valid rises N = 15 - EXP edges after the accept edge. N ranges 1..15; DQM=0 gives N=15.
- D, DS and DLN are stable from out_valid rise until the DONE->IDLE edge. After that edge they hold their last value, qualified by out_valid=0.
- Input changes while in_ready=0 are ignored.
- D wrap-around: only modulo-65536 truncation applies (the range cannot overflow 16 bits). No saturation anywhere.
- Reset in NORM or DONE: aborts the operation with no output pulse; next cycle is IDLE with all outputs at reset values.
- reset and in_valid in the same cycle: reset wins, nothing is accepted.

Test Plan:
- Reset, then SL=0, SE=0, Y=0 -> D=0, DS=0, DLN=0, out_valid after exactly 15 edges; in_ready=0 throughout.
- SL=4096, SE=0, Y=544 -> D=4096, DS=0, EXP=12, DLN=1400, out_valid 3 edges after accept.
- SL=0, SE=100, Y=544 -> D=0xFF9C, DS=1, DL=840, DLN=704, N=9.
- SL=0x2000 (-8192), SE=0x3FFF, Y=0 -> D=0xA001, DS=1, DL=1855, DLN=1855, N=1.
- SL=0x1FFF, SE=0x4000, Y=0 -> D=0x5FFF, DS=0, DLN=1855. Then SL=0, SE=0, Y=8191 -> DLN=2049 (modulo wrap).
- Backpressure and abort:
  - Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
  - Pulse reset during NORM -> out_valid never asserts, in_ready=1 next cycle.
  - Assert in_valid together with reset -> no accept.
